// File: rtl/fetch_stage.sv
// RV32I fetch stage + IF/ID register: one instruction per cycle with zero-wait memory, visible the cycle after resp.
// A stall catches at most one returned word in a buffer and issues no read while holding; a flush mid-request waits out the response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_mem_read,
  output logic [31:0] inst_mem_address,
  input  logic [31:0] inst_mem_rdata,
  input  logic        inst_mem_resp,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        fetch_busy,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
);

  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] redir_pc;

  assign redir_pc = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;

    unique case (state_q)
      FETCH: begin
        if (flush) begin
          if_id_valid_d = 1'b0;
          if_id_pc_d    = 32'h0;
          if_id_instr_d = NOP_INSTR;
          if (inst_mem_resp) begin
            pc_d = redir_pc;
          end else begin
            // address must stay put until the outstanding read completes
            pending_pc_d = redir_pc;
            state_d      = DISCARD;
          end
        end else if (inst_mem_resp) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            buf_pc_d    = pc_q;
            buf_instr_d = inst_mem_rdata;
            state_d     = HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = inst_mem_rdata;
          end
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
          if_id_pc_d    = 32'h0;
          if_id_instr_d = NOP_INSTR;
        end
      end
      DISCARD: begin
        if_id_valid_d = 1'b0;
        if_id_pc_d    = 32'h0;
        if_id_instr_d = NOP_INSTR;
        if (flush) pending_pc_d = redir_pc;
        if (inst_mem_resp) begin
          pc_d    = flush ? redir_pc : pending_pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d          = redir_pc;
          if_id_valid_d = 1'b0;
          if_id_pc_d    = 32'h0;
          if_id_instr_d = NOP_INSTR;
          state_d       = FETCH;
        end else if (!stall) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = buf_pc_q;
          if_id_instr_d = buf_instr_q;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pending_pc_q  <= 32'h0;
      buf_pc_q      <= 32'h0;
      buf_instr_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign inst_mem_read    = !rst && (state_q != HOLD);
  assign inst_mem_address = pc_q;
  assign fetch_busy       = !rst && ((state_q == DISCARD) || ((state_q == FETCH) && !inst_mem_resp));

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign opcode      = if_id_instr_q[6:0];
  assign rd          = if_id_instr_q[11:7];
  assign funct3      = if_id_instr_q[14:12];
  assign rs1         = if_id_instr_q[19:15];
  assign rs2         = if_id_instr_q[24:20];
  assign funct7      = if_id_instr_q[31:25];

endmodule
